decode_stage: RTL

- RV64 instruction-decode pipeline stage between fetch and execute.
- Takes one instruction per beat from fetch, extracts fields and drives the register file read addresses.
- Generates the sign-extended immediate and bypasses the same-cycle writeback, because the register file reads asynchronously and writes on the clock edge.
- Registers the decoded bundle into a single-entry valid/ready output slot feeding execute.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/imm_gen.sv | 53 +++++
 rtl/decode_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV64 shared constants, opcodes and immediate-format enum
package riscv_pkg;

   localparam int RV_XLEN_POW  = 6;
   localparam int RV_XLEN      = 1 << RV_XLEN_POW;
   localparam int RV_REG_IDX_W = 5;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_FENCE     = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   // Every supported opcode ends in 2'b11, so this also rejects compressed encodings.
   function automatic logic is_known_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC,
         OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_32, OPC_OP_IMM_32, OPC_SYSTEM,
         OPC_FENCE: is_known_opcode = 1'b1;
         default:   is_known_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate classifier and sign-extender
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output imm_type_e       o_imm_type
);

   logic            w_sign;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_j;

   assign w_sign  = i_instr[31];
   assign w_imm_i = {{(XLEN-12){w_sign}}, i_instr[31:20]};
   assign w_imm_s = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
   assign w_imm_u = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'b0};
   assign w_imm_j = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

   always_comb begin
      o_imm_type = IMM_NONE;
      case (i_instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
            o_imm_type = IMM_I;
         OPC_STORE:            o_imm_type = IMM_S;
         OPC_BRANCH:           o_imm_type = IMM_B;
         OPC_LUI, OPC_AUIPC:   o_imm_type = IMM_U;
         OPC_JAL:              o_imm_type = IMM_J;
         default:              o_imm_type = IMM_NONE;
      endcase
   end

   always_comb begin
      o_imm = '0;
      case (o_imm_type)
         IMM_I:   o_imm = w_imm_i;
         IMM_S:   o_imm = w_imm_s;
         IMM_B:   o_imm = w_imm_b;
         IMM_U:   o_imm = w_imm_u;
         IMM_J:   o_imm = w_imm_j;
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64 decode stage with writeback bypass and a one-entry output slot
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN_POW  = RV_XLEN_POW,
   parameter int REG_IDX_W = RV_REG_IDX_W
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     if_valid_in,
   output logic                     if_ready_out,
   input  logic [31:0]              instr_in,
   input  logic [(1<<XLEN_POW)-1:0] pc_in,
   input  logic                     flush_in,
   output logic [REG_IDX_W-1:0]     rs1_out,
   output logic [REG_IDX_W-1:0]     rs2_out,
   input  logic [(1<<XLEN_POW)-1:0] reg_data1_in,
   input  logic [(1<<XLEN_POW)-1:0] reg_data2_in,
   input  logic                     wb_en_in,
   input  logic [REG_IDX_W-1:0]     wb_rd_in,
   input  logic [(1<<XLEN_POW)-1:0] wb_data_in,
   output logic                     ex_valid_out,
   input  logic                     ex_ready_in,
   output logic [(1<<XLEN_POW)-1:0] ex_pc_out,
   output logic [(1<<XLEN_POW)-1:0] ex_rs1_data_out,
   output logic [(1<<XLEN_POW)-1:0] ex_rs2_data_out,
   output logic [REG_IDX_W-1:0]     ex_rs1_idx_out,
   output logic [REG_IDX_W-1:0]     ex_rs2_idx_out,
   output logic [(1<<XLEN_POW)-1:0] ex_imm_out,
   output logic [REG_IDX_W-1:0]     ex_rd_out,
   output logic [6:0]               ex_opcode_out,
   output logic [2:0]               ex_funct3_out,
   output logic [6:0]               ex_funct7_out,
   output logic                     ex_illegal_out
);

   localparam int XLEN = 1 << XLEN_POW;

   logic                 r_valid;
   logic [XLEN-1:0]      r_pc;
   logic [XLEN-1:0]      r_rs1_data;
   logic [XLEN-1:0]      r_rs2_data;
   logic [REG_IDX_W-1:0] r_rs1_idx;
   logic [REG_IDX_W-1:0] r_rs2_idx;
   logic [XLEN-1:0]      r_imm;
   logic [REG_IDX_W-1:0] r_rd;
   logic [6:0]           r_opcode;
   logic [2:0]           r_funct3;
   logic [6:0]           r_funct7;
   logic                 r_illegal;

   logic                 w_accept;
   logic                 w_illegal;
   logic [XLEN-1:0]      w_imm;
   imm_type_e            w_imm_type;
   logic [REG_IDX_W-1:0] w_rs1;
   logic [REG_IDX_W-1:0] w_rs2;
   logic [REG_IDX_W-1:0] w_rd;
   logic [XLEN-1:0]      w_op1;
   logic [XLEN-1:0]      w_op2;
   logic                 w_snoop1;
   logic                 w_snoop2;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr    (instr_in),
      .o_imm      (w_imm),
      .o_imm_type (w_imm_type)
   );

   assign w_rs1   = instr_in[19:15];
   assign w_rs2   = instr_in[24:20];
   assign rs1_out = w_rs1;
   assign rs2_out = w_rs2;

   assign if_ready_out = !r_valid || ex_ready_in || flush_in;
   assign w_accept     = if_valid_in && if_ready_out;

   assign w_illegal = (instr_in[1:0] != 2'b11) || !is_known_opcode(instr_in[6:0]);
   assign w_rd      = (w_illegal || w_imm_type == IMM_S || w_imm_type == IMM_B)
                      ? '0 : instr_in[11:7];

   // The register file writes on the same edge we sample, so forward the in-flight write.
   always_comb begin
      w_op1 = reg_data1_in;
      if (w_rs1 == '0)
         w_op1 = '0;
      else if (wb_en_in && wb_rd_in == w_rs1)
         w_op1 = wb_data_in;
   end

   always_comb begin
      w_op2 = reg_data2_in;
      if (w_rs2 == '0)
         w_op2 = '0;
      else if (wb_en_in && wb_rd_in == w_rs2)
         w_op2 = wb_data_in;
   end

   assign w_snoop1 = wb_en_in && wb_rd_in != '0 && wb_rd_in == r_rs1_idx;
   assign w_snoop2 = wb_en_in && wb_rd_in != '0 && wb_rd_in == r_rs2_idx;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_rs1_idx  <= '0;
         r_rs2_idx  <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_opcode   <= '0;
         r_funct3   <= '0;
         r_funct7   <= '0;
         r_illegal  <= 1'b0;
      end else if (flush_in) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid    <= 1'b1;
         r_pc       <= pc_in;
         r_rs1_data <= w_op1;
         r_rs2_data <= w_op2;
         r_rs1_idx  <= w_rs1;
         r_rs2_idx  <= w_rs2;
         r_imm      <= w_imm;
         r_rd       <= w_rd;
         r_opcode   <= instr_in[6:0];
         r_funct3   <= instr_in[14:12];
         r_funct7   <= instr_in[31:25];
         r_illegal  <= w_illegal;
      end else if (r_valid && ex_ready_in) begin
         r_valid <= 1'b0;
      end else if (r_valid) begin
         // Held bundle must not go stale while execute is stalled.
         if (w_snoop1) r_rs1_data <= wb_data_in;
         if (w_snoop2) r_rs2_data <= wb_data_in;
      end
   end

   assign ex_valid_out    = r_valid;
   assign ex_pc_out       = r_pc;
   assign ex_rs1_data_out = r_rs1_data;
   assign ex_rs2_data_out = r_rs2_data;
   assign ex_rs1_idx_out  = r_rs1_idx;
   assign ex_rs2_idx_out  = r_rs2_idx;
   assign ex_imm_out      = r_imm;
   assign ex_rd_out       = r_rd;
   assign ex_opcode_out   = r_opcode;
   assign ex_funct3_out   = r_funct3;
   assign ex_funct7_out   = r_funct7;
   assign ex_illegal_out  = r_illegal;

endmodule
